// File: rtl/conv_enc_k3.sv
// conv_enc_k3: rate-1/2, K=3 convolutional encoder (generators 7,5 octal).
// Frames of FRAME_LEN information bits are each followed by two zero tail bits,
// so the shift state returns to 00 at the end of every frame. One coded symbol
// {c_hi, c_lo} is produced per bit into a single registered valid/ready stage.
// Optional build macro CONV_ENC_ERR_INJ_EN: XORs err_inj into each symbol as it
// is loaded. The shift state is never affected.
module conv_enc_k3 #(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sym_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy,
  input  logic [1:0] err_inj
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN);

  logic [1:0] state_q, state_d;
  logic [1:0] st_q, st_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic       tail_cnt_q, tail_cnt_d;
  logic [1:0] sym_q, sym_d;
  logic       out_valid_q, out_valid_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;

  logic       slot_free;
  logic       load;
  logic       enc_bit;
  logic [1:0] inj_mask;

`ifdef CONV_ENC_ERR_INJ_EN
  assign inj_mask = err_inj;
`else
  logic unused_err_inj;
  assign unused_err_inj = ^err_inj;
  assign inj_mask       = 2'b00;
`endif

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && (state_q != S_TAIL);

  assign sym_out   = sym_q;
  assign out_valid = out_valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign busy      = (state_q != S_IDLE);

  // Frame sequencing, encoding and output-register load decisions.
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    sym_d       = sym_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    out_valid_d = out_valid_q && !out_ready;
    load        = 1'b0;
    enc_bit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          load       = 1'b1;
          enc_bit    = in_bit;
          sof_d      = 1'b1;
          eof_d      = 1'b0;
          bit_cnt_d  = 8'd1;
          tail_cnt_d = 1'b0;
          state_d    = (FRAME_LEN == 1) ? S_TAIL : S_DATA;
        end
      end
      S_DATA: begin
        if (in_valid && in_ready) begin
          load      = 1'b1;
          enc_bit   = in_bit;
          sof_d     = 1'b0;
          eof_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_d == LAST_BIT) begin
            state_d    = S_TAIL;
            tail_cnt_d = 1'b0;
          end
        end
      end
      S_TAIL: begin
        if (slot_free) begin
          load       = 1'b1;
          enc_bit    = 1'b0;
          sof_d      = 1'b0;
          eof_d      = tail_cnt_q;
          tail_cnt_d = ~tail_cnt_q;
          if (tail_cnt_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = 8'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      sym_d       = {enc_bit ^ st_q[1] ^ st_q[0], enc_bit ^ st_q[0]} ^ inj_mask;
      out_valid_d = 1'b1;
      st_d        = {enc_bit, st_q[1]};
    end
  end

  // State, counters and output register; async reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= 1'b0;
      sym_q       <= '0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      sym_q       <= sym_d;
      out_valid_q <= out_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

endmodule

// File: tb/tb_conv_enc_k3.sv
// tb_conv_enc_k3: directed scenarios plus a randomized phase for conv_enc_k3
// (FRAME_LEN=4), scored against a generator-polynomial reference model.
module tb_conv_enc_k3;

  localparam int FL = 4;
  localparam logic [2:0] G0 = 3'b111;  // octal 7
  localparam logic [2:0] G1 = 3'b101;  // octal 5
`ifdef CONV_ENC_ERR_INJ_EN
  localparam logic [1:0] INJ_MASK = 2'b11;
`else
  localparam logic [1:0] INJ_MASK = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_bit, in_valid, in_ready;
  logic [1:0] sym_out;
  logic       out_valid, out_ready, out_sof, out_eof, busy;
  logic [1:0] err_inj;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int last_xfer = 0;
  int last_acc  = 0;

  logic       fbits[$];   // information bits (plus tail zeros) of the current frame
  logic [3:0] expq[$];    // expected {sym, sof, eof} in transmit order
  logic [1:0] obsq[$];    // symbols actually transferred

  conv_enc_k3 #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .sym_out(sym_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .err_inj(err_inj)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Symbol for frame position n: parity of the 3-bit window masked by each generator.
  function automatic logic [1:0] enc_at(input int n);
    logic [2:0] w;
    w[2] = fbits[n];
    w[1] = (n >= 1) ? fbits[n-1] : 1'b0;
    w[0] = (n >= 2) ? fbits[n-2] : 1'b0;
    return {^(w & G0), ^(w & G1)};
  endfunction

  task automatic model_accept(input logic b, input logic [1:0] e);
    int n;
    logic [1:0] s;
    n = fbits.size();
    fbits.push_back(b);
    s = enc_at(n) ^ (e & INJ_MASK);
    expq.push_back({s, 1'(n == 0), 1'b0});
    if (fbits.size() == FL) begin
      for (int t = 0; t < 2; t++) begin
        fbits.push_back(1'b0);
        expq.push_back({enc_at(FL + t), 1'b0, 1'(t == 1)});
      end
      fbits.delete();
    end
  endtask

  // One clock: observe handshakes with inputs already driven, then advance.
  task automatic cyc(output bit acc);
    logic       xfer, hold;
    logic [4:0] held;
    logic [3:0] e;
    #1;
    xfer = out_valid && out_ready;
    acc  = in_valid && in_ready;
    hold = out_valid && !out_ready;
    held = {sym_out, out_sof, out_eof, out_valid};
    if (xfer) begin
      obsq.push_back(sym_out);
      last_xfer = cyc_n;
      if (expq.size() == 0) chk("spurious_sym", 32'(out_valid), 32'(0));
      else begin
        e = expq.pop_front();
        chk("sym", 32'(sym_out), 32'(e[3:2]));
        chk("sof", 32'(out_sof), 32'(e[1]));
        chk("eof", 32'(out_eof), 32'(e[0]));
      end
    end
    if (acc) begin
      model_accept(in_bit, err_inj);
      last_acc = cyc_n;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (hold) chk("hold_stable", 32'({sym_out, out_sof, out_eof, out_valid}), 32'(held));
    if (acc)  chk("latency_valid", 32'(out_valid), 32'(1));
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bit a = 1'b0;
    int n = 0;
    in_bit   = b;
    in_valid = 1'b1;
    while (!a && n < 50) begin
      cyc(a);
      n++;
    end
    if (!a) chk("accept_timeout", 32'(a), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_inj   = 2'b00;
    while ((expq.size() != 0 || out_valid) && n < 40) begin
      cyc(a);
      n++;
    end
    chk("drain_empty", 32'(expq.size()), 32'(0));
  endtask

  task automatic expect_list(input string tag, input logic [1:0] l [6]);
    chk({tag, "_count"}, 32'(obsq.size()), 32'(6));
    for (int i = 0; i < 6 && i < obsq.size(); i++)
      chk(tag, 32'(obsq[i]), 32'(l[i]));
  endtask

  logic [1:0] ref1 [6];
  logic [1:0] ref6 [6];

  initial begin
    bit a;
    ref1 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
`ifdef CONV_ENC_ERR_INJ_EN
    ref6 = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
`else
    ref6 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
`endif
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_inj = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_sym",   32'(sym_out),   32'(0));
    chk("rst_sof_eof", 32'({out_sof, out_eof}), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);

    // Scenario 1: bits 1,0,1,1
    obsq.delete();
    send_bit(1'b1);
    chk("s1_busy", 32'(busy), 32'(1));
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    drain();
    chk("s1_idle", 32'(busy), 32'(0));
    expect_list("s1_seq", ref1);

    // Scenario 2: zeros then ones back-to-back, no gap
    out_ready = 1'b1;
    send_bit(1'b0);
    begin
      int first_acc;
      first_acc = last_acc;
      for (int i = 1; i < FL; i++) send_bit(1'b0);
      for (int i = 0; i < FL; i++) send_bit(1'b1);
      drain();
      chk("s2_no_gap", 32'(last_xfer - first_acc), 32'(12));
    end

    // Scenario 3: backpressure after the second symbol
    send_bit(1'b1); send_bit(1'b0);
    out_ready = 1'b0;
    in_bit = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_sym", 32'(sym_out), 32'(2'b10));
      cyc(a);
    end
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    drain();

    // Scenario 4: in_valid gap mid-frame
    send_bit(1'b1); send_bit(1'b1);
    cyc(a);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("gap_no_valid", 32'(out_valid), 32'(0));
      chk("gap_busy", 32'(busy), 32'(1));
      cyc(a);
    end
    send_bit(1'b0); send_bit(1'b1);
    drain();

    // Scenario 5: reset during TAIL, then scenario 1 again
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    cyc(a);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(out_valid), 32'(0));
    chk("s5_rst_sym",   32'(sym_out),   32'(0));
    chk("s5_rst_busy",  32'(busy),      32'(0));
    fbits.delete();
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(a);
    #1;
    chk("s5_in_ready", 32'(in_ready), 32'(1));
    obsq.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    drain();
    expect_list("s5_seq", ref1);

    // Scenario 6: error mask on the third symbol only
    obsq.delete();
    send_bit(1'b1); send_bit(1'b0);
    err_inj = 2'b10;
    send_bit(1'b1);
    err_inj = 2'b00;
    send_bit(1'b1);
    drain();
    expect_list("s6_seq", ref6);

    // Randomized traffic with random backpressure and input gaps
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_bit    = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      cyc(a);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
